// File: rtl/jpeg_tables_pkg.sv
// rtl/jpeg_tables_pkg.sv - JPEG luminance quant tables, zigzag order and read FSM states
package jpeg_tables_pkg;

  typedef enum logic [0:0] {RD_IDLE, RD_SCAN} rd_state_e;

  // Zigzag index k -> natural (row, col) of the 8x8 block
  localparam logic [2:0] ZZ_ROW [64] = '{
    3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0,
    3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
    3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
    3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd6, 3'd7, 3'd7
  };
  localparam logic [2:0] ZZ_COL [64] = '{
    3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
    3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3,
    3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd7
  };

  // Natural (row-major) order, standard JPEG Annex K luminance table
  localparam logic [7:0] Q_LUMA [64] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  // round(65536 / Q_LUMA), same natural order as Q_LUMA
  localparam logic [16:0] RECIP_LUMA [64] = '{
    17'd4096, 17'd5958, 17'd6554, 17'd4096, 17'd2731, 17'd1638, 17'd1285, 17'd1074,
    17'd5461, 17'd5461, 17'd4681, 17'd3449, 17'd2521, 17'd1130, 17'd1092, 17'd1192,
    17'd4681, 17'd5041, 17'd4096, 17'd2731, 17'd1638, 17'd1150, 17'd950,  17'd1170,
    17'd4681, 17'd3855, 17'd2979, 17'd2260, 17'd1285, 17'd753,  17'd819,  17'd1057,
    17'd3641, 17'd2979, 17'd1771, 17'd1170, 17'd964,  17'd601,  17'd636,  17'd851,
    17'd2731, 17'd1872, 17'd1192, 17'd1024, 17'd809,  17'd630,  17'd580,  17'd712,
    17'd1337, 17'd1024, 17'd840,  17'd753,  17'd636,  17'd542,  17'd546,  17'd649,
    17'd910,  17'd712,  17'd690,  17'd669,  17'd585,  17'd655,  17'd636,  17'd662
  };

endpackage

// File: rtl/quant_mul.sv
// rtl/quant_mul.sv - registered reciprocal-multiply quantizer with round-half-up and saturation
module quant_mul #(
  parameter int WIDTH     = 12,
  parameter int OUT_WIDTH = 12,
  parameter int QUANT_EN  = 1
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        in_valid,
  input  logic signed [WIDTH-1:0]     in_coef,
  input  logic [16:0]                 in_recip,
  input  logic [5:0]                  in_idx,
  output logic signed [OUT_WIDTH-1:0] out_coef,
  output logic [5:0]                  out_idx,
  output logic                        out_valid,
  output logic                        out_last
);
  localparam int PW = WIDTH + 19;
  localparam logic signed [PW-1:0] HALF = PW'(32768);
  localparam logic signed [PW-1:0] MAXV = PW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);

  logic signed [PW-1:0]        a, b, p, val, clamped;
  logic signed [OUT_WIDTH-1:0] coef_d, coef_q;
  logic [5:0]                  idx_d, idx_q;
  logic                        valid_d, valid_q, last_d, last_q;

  always_comb begin
    a = PW'(in_coef);
    b = PW'(in_recip);
    p = a * b + HALF;
    // Arithmetic shift floors, so together with +HALF ties round toward +inf
    val = (QUANT_EN != 0) ? (p >>> 16) : a;
    clamped = val;
    if (val > MAXV) clamped = MAXV;
    else if (val < MINV) clamped = MINV;
    coef_d  = OUT_WIDTH'(clamped);
    idx_d   = in_idx;
    valid_d = in_valid;
    last_d  = in_valid && (in_idx == 6'd63);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      coef_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      coef_q  <= coef_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_coef  = coef_q;
  assign out_idx   = idx_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
endmodule

// File: rtl/dct_quant_zigzag.sv
// rtl/dct_quant_zigzag.sv - ping-pong 8x8 block buffer, zigzag readout and quantization
module dct_quant_zigzag
  import jpeg_tables_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int OUT_WIDTH = 12,
  parameter int QUANT_EN  = 1
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic signed [WIDTH-1:0]     in_0,
  input  logic signed [WIDTH-1:0]     in_1,
  input  logic signed [WIDTH-1:0]     in_2,
  input  logic signed [WIDTH-1:0]     in_3,
  input  logic signed [WIDTH-1:0]     in_4,
  input  logic signed [WIDTH-1:0]     in_5,
  input  logic signed [WIDTH-1:0]     in_6,
  input  logic signed [WIDTH-1:0]     in_7,
  input  logic                        valid_in,
  input  logic                        final_row_in,
  output logic signed [OUT_WIDTH-1:0] coef_out,
  output logic [5:0]                  zz_idx_out,
  output logic                        valid_out,
  output logic                        last_out,
  output logic                        overflow_out,
  output logic                        sync_err_out
);
  logic signed [WIDTH-1:0] row [8];
  logic signed [WIDTH-1:0] bank_d [2][8][8], bank_q [2][8][8];
  logic [1:0]              full_d, full_q;
  logic                    wr_bank_d, wr_bank_q, rd_bank_d, rd_bank_q;
  logic [2:0]              row_cnt_d, row_cnt_q;
  logic [5:0]              zz_cnt_d, zz_cnt_q;
  logic                    overflow_d, overflow_q, sync_err_d, sync_err_q;
  rd_state_e               state_d, state_q;
  logic                    rel_en;
  logic                    rd_valid_d, rd_valid_q;
  logic signed [WIDTH-1:0] rd_coef_d, rd_coef_q;
  logic [16:0]             rd_recip_d, rd_recip_q;
  logic [5:0]              rd_idx_d, rd_idx_q;

  always_comb begin
    row[0] = in_0; row[1] = in_1; row[2] = in_2; row[3] = in_3;
    row[4] = in_4; row[5] = in_5; row[6] = in_6; row[7] = in_7;
  end

  // Read FSM: walks the oldest full bank in zigzag order, chaining banks without a bubble
  always_comb begin
    state_d    = state_q;
    zz_cnt_d   = zz_cnt_q;
    rd_bank_d  = rd_bank_q;
    rel_en     = 1'b0;
    rd_valid_d = 1'b0;
    rd_coef_d  = rd_coef_q;
    rd_recip_d = rd_recip_q;
    rd_idx_d   = zz_cnt_q;
    case (state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d  = RD_SCAN;
          zz_cnt_d = 6'd0;
        end
      end
      RD_SCAN: begin
        rd_valid_d = 1'b1;
        rd_coef_d  = bank_q[rd_bank_q][ZZ_ROW[zz_cnt_q]][ZZ_COL[zz_cnt_q]];
        rd_recip_d = RECIP_LUMA[{ZZ_ROW[zz_cnt_q], ZZ_COL[zz_cnt_q]}];
        if (zz_cnt_q == 6'd63) begin
          rel_en    = 1'b1;
          rd_bank_d = ~rd_bank_q;
          zz_cnt_d  = 6'd0;
          if (!full_q[~rd_bank_q]) state_d = RD_IDLE;
        end else begin
          zz_cnt_d = zz_cnt_q + 6'd1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Write side; a bank released this cycle still looks full to the writer until next cycle
  always_comb begin
    bank_d     = bank_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    row_cnt_d  = row_cnt_q;
    overflow_d = overflow_q;
    sync_err_d = sync_err_q;
    if (rel_en) full_d[rd_bank_q] = 1'b0;
    if (valid_in) begin
      if (full_q[wr_bank_q]) begin
        overflow_d = 1'b1;
      end else begin
        for (int c = 0; c < 8; c++) bank_d[wr_bank_q][row_cnt_q][c] = row[c];
        if (row_cnt_q == 3'd7 && final_row_in) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
          row_cnt_d         = 3'd0;
        end else if (row_cnt_q == 3'd7 || final_row_in) begin
          sync_err_d = 1'b1;
          row_cnt_d  = 3'd0;
        end else begin
          row_cnt_d = row_cnt_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    bank_q <= bank_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      row_cnt_q  <= '0;
      zz_cnt_q   <= '0;
      overflow_q <= 1'b0;
      sync_err_q <= 1'b0;
      state_q    <= RD_IDLE;
      rd_valid_q <= 1'b0;
      rd_coef_q  <= '0;
      rd_recip_q <= '0;
      rd_idx_q   <= '0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      row_cnt_q  <= row_cnt_d;
      zz_cnt_q   <= zz_cnt_d;
      overflow_q <= overflow_d;
      sync_err_q <= sync_err_d;
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_coef_q  <= rd_coef_d;
      rd_recip_q <= rd_recip_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  quant_mul #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .QUANT_EN(QUANT_EN)) u_quant (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .in_valid (rd_valid_q),
    .in_coef  (rd_coef_q),
    .in_recip (rd_recip_q),
    .in_idx   (rd_idx_q),
    .out_coef (coef_out),
    .out_idx  (zz_idx_out),
    .out_valid(valid_out),
    .out_last (last_out)
  );

  assign overflow_out = overflow_q;
  assign sync_err_out = sync_err_q;
endmodule

// File: tb/tb_dct_quant_zigzag.sv
// tb/tb_dct_quant_zigzag.sv - scoreboard bench: quantizing DUT and 8-bit pass-through DUT
module tb_dct_quant_zigzag;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in, valid_in, final_row_in;
  logic signed [11:0] in_v [8];
  logic signed [11:0] q_coef;
  logic signed [7:0]  p_coef;
  logic [5:0] q_idx, p_idx;
  logic q_valid, q_last, q_ovf, q_serr, p_valid, p_last, p_ovf, p_serr;

  dct_quant_zigzag #(.WIDTH(12), .OUT_WIDTH(12), .QUANT_EN(1)) dut_q (
    .clk_in(clk), .rst_in(rst_in),
    .in_0(in_v[0]), .in_1(in_v[1]), .in_2(in_v[2]), .in_3(in_v[3]),
    .in_4(in_v[4]), .in_5(in_v[5]), .in_6(in_v[6]), .in_7(in_v[7]),
    .valid_in(valid_in), .final_row_in(final_row_in),
    .coef_out(q_coef), .zz_idx_out(q_idx), .valid_out(q_valid), .last_out(q_last),
    .overflow_out(q_ovf), .sync_err_out(q_serr));

  dct_quant_zigzag #(.WIDTH(12), .OUT_WIDTH(8), .QUANT_EN(0)) dut_p (
    .clk_in(clk), .rst_in(rst_in),
    .in_0(in_v[0]), .in_1(in_v[1]), .in_2(in_v[2]), .in_3(in_v[3]),
    .in_4(in_v[4]), .in_5(in_v[5]), .in_6(in_v[6]), .in_7(in_v[7]),
    .valid_in(valid_in), .final_row_in(final_row_in),
    .coef_out(p_coef), .zz_idx_out(p_idx), .valid_out(p_valid), .last_out(p_last),
    .overflow_out(p_ovf), .sync_err_out(p_serr));

  typedef struct {int coef; int idx;} exp_t;
  exp_t exp_q[$], exp_p[$];
  exp_t eq_item, ep_item;
  int n_cmp = 0, n_bad = 0;
  int blk [8][8];
  int zr [64], zc [64];
  int run_cur = 0, last_run = 0;

  int QT [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Zigzag walk over anti-diagonals: odd diagonals go down-left, even go up-right
  function automatic void build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 1) for (int r = lo; r <= hi; r++) begin zr[k] = r; zc[k] = s - r; k++; end
      else            for (int r = hi; r >= lo; r--) begin zr[k] = r; zc[k] = s - r; k++; end
    end
  endfunction

  function automatic int sat(input int v, input int w);
    int mx = (1 << (w - 1)) - 1;
    if (v > mx) return mx;
    if (v < -mx - 1) return -mx - 1;
    return v;
  endfunction

  function automatic int quant_ref(input int v, input int r, input int c);
    longint q = longint'(QT[r * 8 + c]);
    longint recip = (131072 + q) / (2 * q);
    longint pr = longint'(v) * recip;
    return sat(int'((pr + 32768) >>> 16), 12);
  endfunction

  function automatic void push_expect();
    for (int k = 0; k < 64; k++) begin
      exp_q.push_back('{quant_ref(blk[zr[k]][zc[k]], zr[k], zc[k]), k});
      exp_p.push_back('{sat(blk[zr[k]][zc[k]], 8), k});
    end
  endfunction

  function automatic void fill_zero();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) blk[r][c] = 0;
  endfunction

  function automatic void fill_rand();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++)
      blk[r][c] = int'($urandom_range(4095)) - 2048;
  endfunction

  task automatic drive_row(input int r, input bit fin);
    for (int c = 0; c < 8; c++) in_v[c] = 12'(blk[r][c]);
    valid_in = 1'b1;
    final_row_in = fin;
    @(posedge clk); #1;
    valid_in = 1'b0;
    final_row_in = 1'b0;
  endtask

  task automatic send_block(input bit expect_out, input int n_rows, input int fin_at, input int gap_max);
    if (expect_out) push_expect();
    for (int r = 0; r < n_rows; r++) begin
      repeat ($urandom_range(gap_max)) begin @(posedge clk); #1; end
      drive_row(r, r == fin_at);
    end
  endtask

  task automatic lat_check();
    @(posedge clk); #1; check("lat_edge1_valid", int'(q_valid), 0);
    @(posedge clk); #1; check("lat_edge2_valid", int'(q_valid), 0);
    @(posedge clk); #1; check("lat_edge3_valid", int'(q_valid), 1);
    check("lat_edge3_idx", int'(q_idx), 0);
    check("lat_edge3_p_valid", int'(p_valid), 1);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || exp_p.size() != 0) && t < 600) begin @(posedge clk); t++; end
    check("drain_q_left", exp_q.size(), 0);
    check("drain_p_left", exp_p.size(), 0);
    exp_q.delete();
    exp_p.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_in) begin
      if (q_valid) begin
        if (exp_q.size() == 0) check("q_unexpected_output_idx", int'(q_idx), -1);
        else begin
          eq_item = exp_q.pop_front();
          check("q_coef", int'(q_coef), eq_item.coef);
          check("q_idx", int'(q_idx), eq_item.idx);
          check("q_last", int'(q_last), int'(eq_item.idx == 63));
        end
        run_cur++;
      end else begin
        if (run_cur > 0) last_run = run_cur;
        run_cur = 0;
      end
      if (p_valid) begin
        if (exp_p.size() == 0) check("p_unexpected_output_idx", int'(p_idx), -1);
        else begin
          ep_item = exp_p.pop_front();
          check("p_coef", int'(p_coef), ep_item.coef);
          check("p_idx", int'(p_idx), ep_item.idx);
          check("p_last", int'(p_last), int'(ep_item.idx == 63));
        end
      end
    end
  end

  initial begin
    int t;
    build_zz();
    rst_in = 1'b1; valid_in = 1'b0; final_row_in = 1'b0;
    for (int c = 0; c < 8; c++) in_v[c] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(q_valid), 0);
    check("rst_coef", int'(q_coef), 0);
    check("rst_idx", int'(q_idx), 0);
    check("rst_last", int'(q_last), 0);
    check("rst_ovf", int'(q_ovf), 0);
    check("rst_serr", int'(q_serr), 0);
    check("rst_p_valid", int'(p_valid), 0);
    rst_in = 1'b0;
    @(posedge clk); #1;

    fill_zero(); blk[0][0] = 800;
    send_block(1'b1, 8, 7, 0); lat_check(); drain();
    fill_zero(); blk[0][0] = -800;
    send_block(1'b1, 8, 7, 0); drain();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) blk[r][c] = 8 * r + c;
    send_block(1'b1, 8, 7, 0); drain();
    check("clean_ovf", int'(q_ovf), 0);
    check("clean_serr", int'(q_serr), 0);

    for (int i = 0; i < 3; i++) begin
      fill_rand(); send_block(1'b1, 8, 7, 2);
      fill_rand(); send_block(1'b1, 8, 7, 2);
      drain();
    end

    fill_rand(); send_block(1'b1, 8, 7, 0);
    fill_rand(); send_block(1'b1, 8, 7, 0);
    fill_rand(); send_block(1'b0, 8, 7, 0);
    drain();
    check("pingpong_run_len", last_run, 128);
    check("overflow_q", int'(q_ovf), 1);
    check("overflow_p", int'(p_ovf), 1);

    fill_rand(); send_block(1'b0, 5, 4, 1);
    repeat (4) @(posedge clk);
    #1;
    check("sync_early_final_q", int'(q_serr), 1);
    check("sync_early_final_p", int'(p_serr), 1);
    check("sync_no_output", exp_q.size() + int'(q_valid), 0);
    fill_rand(); send_block(1'b0, 8, -1, 0);
    fill_rand(); send_block(1'b1, 8, 7, 1);
    drain();

    fill_zero(); blk[0][0] = 300;  send_block(1'b1, 8, 7, 0);
    fill_zero(); blk[0][0] = -300; send_block(1'b1, 8, 7, 0);
    drain();

    fill_rand(); send_block(1'b1, 8, 7, 0);
    t = 0;
    while (!(q_valid && q_idx == 6'd20) && t < 300) begin @(posedge clk); #1; t++; end
    check("wait_zz20", int'(q_valid && q_idx == 6'd20), 1);
    rst_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    exp_q.delete(); exp_p.delete();
    check("after_rst_valid", int'(q_valid), 0);
    check("after_rst_p_valid", int'(p_valid), 0);
    check("after_rst_ovf", int'(q_ovf), 0);
    check("after_rst_serr", int'(q_serr), 0);
    fill_rand(); send_block(1'b1, 8, 7, 0); lat_check(); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dct_quant_zigzag.md
Name: dct_quant_zigzag

Overview:
- Downstream neighbour of the 8x8 transpose buffer in the 2D-DCT encode path.
- Collects the 8 transposed coefficient rows of one block into a ping-pong bank.
- Quantizes each coefficient by the fixed JPEG luminance table, using a reciprocal multiply.
- Emits the 64 results serially, one per cycle, in JPEG zigzag order, to the run-length/entropy stage.

Parameters:
- WIDTH, 12: signed input coefficient width; matches the transpose buffer.
- OUT_WIDTH, 12: signed quantized output width.
- QUANT_EN, 1: 1 = quantize; 0 = pass the coefficient through, still saturated to OUT_WIDTH.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset
- in_0..in_7  input  WIDTH each  signed row; in_c = coefficient (row r, column c)
- valid_in  input  1  row strobe, one row per asserted cycle, rows arrive in order 0..7
- final_row_in  input  1  marks row 7 of a block; qualified by valid_in
- coef_out  output  OUT_WIDTH  signed quantized coefficient
- zz_idx_out  output  6  zigzag index 0..63 of coef_out
- valid_out  output  1  coef_out/zz_idx_out valid
- last_out  output  1  high with valid_out when zz_idx_out==63
- overflow_out  output  1  sticky: a row was dropped because no bank was free
- sync_err_out  output  1  sticky: final_row_in disagreed with the row count

Behaviour:
- One clock, clk_in. rst_in is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - Both banks empty; write row counter 0; read side idle.
  - Sticky flags cleared.
  - Reset mid-block discards all buffered and in-flight data. valid_out is 0 on the cycle after reset.
- No backpressure exists on either side.
- Write side:
  - Rows are written into the current write bank at row_cnt.
  - A row is accepted only if the write bank is not full. Otherwise it is dropped and overflow_out is set.
  - At row_cnt==7, final_row_in must be 1. The bank is then marked full, row_cnt becomes 0, and the write bank toggles.
  - final_row_in=1 with row_cnt!=7: sync_err_out is set, the partial bank is discarded, and row_cnt returns to 0.
  - row_cnt==7 with final_row_in=0: same discard and flag.
- Read side FSM:
  - IDLE -> SCAN when a full bank exists.
  - In SCAN, zz_cnt runs 0..63. Index k reads bank[row(k)][col(k)] through the zigzag LUT. Standard JPEG order: k=0..5 -> (0,0),(0,1),(1,0),(2,0),(1,1),(0,2).
  - At k=63 the bank is released (marked empty).
  - If the other bank is already full when k=63 is issued, SCAN continues into it with no bubble. Otherwise the FSM returns to IDLE.
- Latency:
  - First valid_out is on the 3rd rising edge after the edge that captures row 7: one cycle for the bank flag, one for the read register, one for the multiply register.
  - valid_out then stays high for 64 consecutive cycles per block.
- Arithmetic:
  - p = coef * RECIP[k], where RECIP = round(65536/Q), a 17-bit unsigned value.
  - result = (p + 32768) >>> 16, i.e. rounding half toward +inf.
  - The result saturates to OUT_WIDTH.
  - With QUANT_EN=0, result = coef, saturated.
- A write and a read release of the same bank can occur in the same cycle. The bank is free to the writer on the following cycle.

Decomposition:
- Package jpeg_tables_pkg holds:
  - ZZ_ROW / ZZ_COL 64-entry constants.
  - Q_LUMA and RECIP_LUMA 64-entry constants.
  - The read FSM enum.
- Sub-module quant_mul: one-cycle registered signed×unsigned multiply with rounding and saturation.

Test Plan:
- DC only:
  - Stimulus: row0 in_0=800, all other coefficients 0, 8 rows back to back, final_row_in on row 7.
  - Response: first valid_out 3 cycles after row 7; zz 0 coef=50; zz 1..63 coef=0; last_out only at zz 63.
- Negative DC:
  - Stimulus: in_0=-800 on row0.
  - Response: zz 0 coef=-50 (round-half check: -49.5 -> -50 via floor).
- Zigzag order:
  - Stimulus: QUANT_EN=0, element (r,c)=8r+c.
  - Response: coef sequence starts 0,1,8,16,9,2,3,10 and ends 63 at zz 63.
- Ping-pong and overflow:
  - Stimulus: blocks A and B over 16 consecutive row cycles, then block C rows starting on cycle 16.
  - Response: 128 contiguous valid_out cycles (A then B); C rows dropped; overflow_out=1.
- Sync error and saturation:
  - Stimulus: final_row_in on row 4.
  - Response: sync_err_out=1; no output; next clean block emitted normally.
  - Stimulus: QUANT_EN=0, OUT_WIDTH=8, in_0=300 then -300 (two blocks).
  - Response: coef 127 and -128.
- Reset mid-scan:
  - Stimulus: assert rst_in at zz 20.
  - Response: valid_out=0 next cycle; flags cleared; next block starts at zz 0 with normal latency.
